// File: rtl/pcie_rx_defs.sv
// Shared definitions for the lane receive descrambler:
// K-symbol values, default seed/TS length, FSM states, LFSR helpers.
package pcie_rx_defs;

  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] SKP = 8'h1C;
  localparam logic [7:0] PAD = 8'hF7;

  localparam logic [15:0] DefSeed  = 16'hFFFF;
  localparam int          DefTsLen = 16;

  typedef enum logic [1:0] {
    NORM    = 2'd0,
    POSTCOM = 2'd1,
    TS      = 2'd2
  } rxSt_t;

  // Galois form of x^16+x^5+x^4+x^3+1, one step per serial bit.
  function automatic logic [15:0] lfsrAdv8(
    input logic [15:0] s
  );
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 8; i++) begin
      if (r[15]) r = {r[14:0], 1'b0} ^ 16'h0039;
      else       r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // Taps never reach bit 15 within 8 steps, so the
  // next 8 serial outputs are just the top byte reversed.
  function automatic logic [7:0] lfsrMask(
    input logic [15:0] s
  );
    logic [7:0] m;
    for (int i = 0; i < 8; i++) m[i] = s[15-i];
    return m;
  endfunction

endpackage

// File: rtl/rx_scramble_ctrl_lfsr8.sv
// 16-bit descramble LFSR: seed, hold or 8-step advance.
// Ports: ClkPci, notReset, Load, Adv, Mask (8-bit current-byte mask).
module rx_lfsr8
  import pcie_rx_defs::*;
#(
  parameter logic [15:0] SEED = DefSeed
) (
  input  logic       ClkPci,
  input  logic       notReset,
  input  logic       Load,
  input  logic       Adv,
  output logic [7:0] Mask
);

  logic [15:0] lfsr;

  always_ff @(posedge ClkPci or negedge notReset) begin
    if (!notReset)  lfsr <= SEED;
    else if (Load)  lfsr <= SEED;
    else if (Adv)   lfsr <= lfsrAdv8(lfsr);
  end

  assign Mask = lfsrMask(lfsr);

endmodule

// File: rtl/rx_scramble_ctrl.sv
// Rx descrambler controller for one lane: ordered-set tracking,
// LFSR sequencing, per-byte mask/enable and TS abort pulse.
// In: ClkPci, notReset, DecodeValid/Ctrl/Byte, ScrambleDisable.
// Out: NextScramble, NextScXor, InTs, TsAbort.
module rx_scramble_ctrl
  import pcie_rx_defs::*;
#(
  parameter logic [15:0] SEED  = DefSeed,
  parameter int          TSLEN = DefTsLen
) (
  input  logic       ClkPci,
  input  logic       notReset,
  input  logic       DecodeValid,
  input  logic       DecodeCtrl,
  input  logic [7:0] DecodeByte,
  input  logic       ScrambleDisable,
  output logic       NextScramble,
  output logic [7:0] NextScXor,
  output logic       InTs,
  output logic       TsAbort
);

  localparam logic [3:0] TsCnt = 4'(TSLEN - 3);

  rxSt_t      st, stNext;
  logic [3:0] cnt, cntNext;
  logic       abortNext;
  logic       isCom, isSkp, isPad;

  assign isCom = DecodeCtrl & (DecodeByte == COM);
  assign isSkp = DecodeCtrl & (DecodeByte == SKP);
  assign isPad = DecodeCtrl & (DecodeByte == PAD);

  rx_lfsr8 #(
    .SEED(SEED)
  ) uLfsr (
    .ClkPci  (ClkPci),
    .notReset(notReset),
    .Load    (DecodeValid & isCom),
    .Adv     (DecodeValid & ~isCom & ~isSkp),
    .Mask    (NextScXor)
  );

  always_ff @(posedge ClkPci or negedge notReset) begin
    if (!notReset) begin
      st      <= NORM;
      cnt     <= 4'd0;
      TsAbort <= 1'b0;
    end else begin
      st      <= stNext;
      cnt     <= cntNext;
      TsAbort <= abortNext;
    end
  end

  always_comb begin
    stNext    = st;
    cntNext   = cnt;
    abortNext = 1'b0;
    if (DecodeValid) begin
      unique case (st)
        NORM: begin
          if (isCom) stNext = POSTCOM;
        end
        POSTCOM: begin
          if (~DecodeCtrl | isPad) begin
            stNext  = TS;
            cntNext = TsCnt;
          end else if (!isCom) begin
            stNext = NORM;
          end
        end
        TS: begin
          if (isCom) begin
            stNext    = POSTCOM;
            abortNext = 1'b1;
          end else if (cnt == 4'd0) begin
            stNext = NORM;
          end else begin
            cntNext = cnt - 4'd1;
          end
        end
        default: stNext = NORM;
      endcase
    end
  end

  assign InTs = (st == TS)
              | ((st == POSTCOM) & DecodeValid
                 & (~DecodeCtrl | isPad));

  assign NextScramble = DecodeValid & ~DecodeCtrl
                      & ~ScrambleDisable & ~InTs;

endmodule

// File: tb/tb_rx_scramble_ctrl.sv
// Directed bench for rx_scramble_ctrl with a queued scoreboard.
// Stimulus pushes expectations; a negedge monitor pops and checks.
module tb_rx_scramble_ctrl;

  logic       ClkPci = 1'b0;
  logic       notReset = 1'b0;
  logic       DecodeValid = 1'b0;
  logic       DecodeCtrl = 1'b0;
  logic [7:0] DecodeByte = 8'h00;
  logic       ScrambleDisable = 1'b0;
  logic       NextScramble;
  logic [7:0] NextScXor;
  logic       InTs;
  logic       TsAbort;

  always #5 ClkPci = ~ClkPci;

  rx_scramble_ctrl dut (
    .ClkPci         (ClkPci),
    .notReset       (notReset),
    .DecodeValid    (DecodeValid),
    .DecodeCtrl     (DecodeCtrl),
    .DecodeByte     (DecodeByte),
    .ScrambleDisable(ScrambleDisable),
    .NextScramble   (NextScramble),
    .NextScXor      (NextScXor),
    .InTs           (InTs),
    .TsAbort        (TsAbort)
  );

  typedef struct {
    logic       ns;
    logic       ints;
    logic       ab;
    logic [7:0] m;
    bit         cm;
    string      nm;
  } exp_t;

  exp_t q[$];
  int nCmp = 0;
  int nBad = 0;

  // Masks for successive bytes from seed FFFF.
  logic [7:0] seq [16] = '{
    8'hFF, 8'h17, 8'hC0, 8'h14, 8'hB2, 8'hE7, 8'h02, 8'h82,
    8'h72, 8'h6E, 8'h28, 8'hA6, 8'hBE, 8'h6D, 8'hBF, 8'h8D
  };

  task automatic chk(string nm, string fld,
                     logic [7:0] act, logic [7:0] req);
    nCmp++;
    if (act !== req) begin
      nBad++;
      $display("FAIL %s.%s actual=%h required=%h @%0t",
               nm, fld, act, req, $time);
    end
  endtask

  always @(negedge ClkPci) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "NextScramble", {7'd0, NextScramble}, {7'd0, e.ns});
      chk(e.nm, "InTs", {7'd0, InTs}, {7'd0, e.ints});
      chk(e.nm, "TsAbort", {7'd0, TsAbort}, {7'd0, e.ab});
      if (e.cm) chk(e.nm, "NextScXor", NextScXor, e.m);
    end
  end

  task automatic step(string nm, bit r, bit v, bit c,
                      logic [7:0] b, bit sd, bit ens, bit ei,
                      bit ea, logic [7:0] em, bit cm);
    exp_t e;
    @(posedge ClkPci);
    #1;
    notReset        = r;
    DecodeValid     = v;
    DecodeCtrl      = c;
    DecodeByte      = b;
    ScrambleDisable = sd;
    e.ns = ens; e.ints = ei; e.ab = ea;
    e.m = em; e.cm = cm; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic d(string nm, bit sd, bit ens, bit ei,
                   logic [7:0] m);
    step(nm, 1, 1, 0, 8'h00, sd, ens, ei, 0, m, 1);
  endtask

  task automatic k(string nm, logic [7:0] b, bit ei,
                   logic [7:0] m, bit cm);
    step(nm, 1, 1, 1, b, 0, 0, ei, 0, m, cm);
  endtask

  task automatic idle(string nm, bit ea, logic [7:0] m);
    step(nm, 1, 0, 0, 8'h00, 0, 0, 0, ea, m, 1);
  endtask

  task automatic rst(string nm);
    step(nm, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'hFF, 1);
  endtask

  initial begin
    int waitCnt;
    for (int i = 0; i < 3; i++) rst("reset");

    // COM, SKP, then data from the seed
    k("t1_com", 8'hBC, 0, 8'hFF, 1);
    k("t1_skp", 8'h1C, 0, 8'hFF, 1);
    for (int i = 0; i < 3; i++) d("t1_data", 0, 1, 0, seq[i]);

    // SKPs hold the LFSR
    k("t2_com", 8'hBC, 0, seq[3], 1);
    for (int i = 0; i < 3; i++) k("t2_skp", 8'h1C, 0, 8'hFF, 1);
    d("t2_data", 0, 1, 0, 8'hFF);

    // full TS ordered set: unscrambled but LFSR runs
    k("t3_com", 8'hBC, 0, seq[1], 1);
    k("t3_pad", 8'hF7, 1, 8'hFF, 1);
    for (int i = 1; i <= 14; i++) d("t3_ts", 0, 0, 1, seq[i]);
    d("t3_after", 0, 1, 0, seq[15]);

    // disable toggle and valid gap keep alignment
    k("t5_com", 8'hBC, 0, 8'h00, 0);
    k("t5_skp", 8'h1C, 0, 8'hFF, 1);
    d("t5_sd", 1, 0, 0, seq[0]);
    d("t5_d1", 0, 1, 0, seq[1]);
    d("t5_d2", 0, 1, 0, seq[2]);
    for (int i = 0; i < 5; i++) idle("t5_gap", 0, seq[3]);
    d("t5_d3", 0, 1, 0, seq[3]);
    d("t5_d4", 0, 1, 0, seq[4]);

    // COM inside TS aborts and re-seeds
    k("t4_com", 8'hBC, 0, seq[5], 1);
    d("t4_ts1", 0, 0, 1, seq[0]);
    for (int i = 1; i <= 4; i++) d("t4_ts", 0, 0, 1, seq[i]);
    k("t4_abcom", 8'hBC, 1, seq[5], 1);
    idle("t4_pulse", 1, 8'hFF);
    idle("t4_clear", 0, 8'hFF);
    k("t4_postcom", 8'hF7, 1, 8'hFF, 1);

    // disabled scrambling, then reset in mid-TS
    d("t6_ts1", 1, 0, 1, seq[1]);
    d("t6_ts2", 1, 0, 1, seq[2]);
    step("t6_com", 1, 1, 1, 8'hBC, 1, 0, 1, 0, seq[3], 1);
    rst("t6_rst");
    rst("t6_rst2");
    step("t6_rel", 1, 0, 0, 8'h00, 1, 0, 0, 0, 8'hFF, 1);
    d("t6_sd", 1, 0, 0, seq[0]);
    d("t6_d", 0, 1, 0, seq[1]);
    idle("t6_idle", 0, seq[2]);

    waitCnt = 0;
    while (q.size() > 0 && waitCnt < 20) begin
      @(posedge ClkPci);
      waitCnt++;
    end
    if (q.size() > 0) begin
      nCmp++;
      nBad++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/rx_scramble_ctrl.md
# rx_scramble_ctrl

Receive-side descrambler controller for one PCIe lane of the physical (logical) layer. It sits between the 8b/10b decoder and the Rx data path, and owns the 16-bit descrambling LFSR per Base Specification 1.0a section 4.2.3. Each cycle it drives the per-byte scramble mask and the scramble-enable qualifier that the data path applies to the current decoded byte. It tracks COM, SKP and TS1/TS2 ordered-set boundaries, so the LFSR is re-seeded, held or bypassed exactly as the specification requires.

## Interface
Parameters:
- SEED, 16'hFFFF, LFSR value loaded at reset and on every COM.
- TSLEN, 16, total TS1/TS2 ordered-set length in symbols, including the COM.

Ports:
- ClkPci  input  1  lane symbol clock; all state changes on the rising edge.
- notReset  input  1  asynchronous, active-low reset.
- DecodeValid  input  1  the decoder presents a symbol this cycle.
- DecodeCtrl  input  1  the current symbol is a K code.
- DecodeByte  input  8  current decoded symbol value.
- ScrambleDisable  input  1  from LTSSM; forces NextScramble low. The LFSR keeps running.
- NextScramble  output  1  the current byte must be descrambled.
- NextScXor  output  8  descramble mask for the current byte.
- InTs  output  1  the current symbol belongs to symbols 1..TSLEN-1 of a TS ordered set.
- TsAbort  output  1  one-cycle registered pulse: a COM arrived before the TS ordered set completed.

## Operation
Symbol constants:
- COM = K 8'hBC
- SKP = K 8'h1C
- PAD = K 8'hF7

LFSR:
- Polynomial x^16+x^5+x^4+x^3+1.
- NextScXor is the 8 LFSR output bits for the current symbol. Bit 0 is the first serial bit.
- Starting from SEED, successive data bytes must yield masks 8'hFF, 8'h17, 8'hC0, 8'h14, 8'hB2.
- LFSR update on an accepted symbol (DecodeValid=1), highest priority first:
  - COM: load SEED.
  - SKP: hold.
  - Any other symbol: advance 8 steps.
- DecodeValid=0: hold all state.

State machine (state register st, 4-bit count cnt):
- NORM: COM goes to POSTCOM.
- POSTCOM:
  - D symbol or PAD: go to TS, cnt <= TSLEN-3.
  - COM: stay in POSTCOM.
  - SKP or any other K symbol: go to NORM.
- TS:
  - COM: go to POSTCOM and pulse TsAbort.
  - Otherwise, cnt=0 goes to NORM; else cnt decrements.

NextScramble (combinational) = DecodeValid & ~DecodeCtrl & ~ScrambleDisable & ~InTs.

InTs (combinational) = (st==TS) | (st==POSTCOM & DecodeValid & (~DecodeCtrl | DecodeByte==PAD)).

With these rules, symbols 1..15 of a TS ordered set are unscrambled and the LFSR still advances across them.

## Timing
- NextScramble, NextScXor and InTs are valid in the same cycle as DecodeByte, with zero latency.
  - NextScXor comes straight from the LFSR register.
  - The data path registers byte^mask on the following edge.
- State, cnt and LFSR update on the rising ClkPci edge after an accepted symbol.
- TsAbort is registered; it is asserted for exactly one cycle, in the cycle after the aborting COM.
- Reset values:
  - LFSR = SEED, so NextScXor = 8'hFF.
  - st = NORM, cnt = 0.
  - TsAbort = 0.
  - NextScramble and InTs are 0 while DecodeValid=0.
- Reset asserted mid-packet or mid-TS returns immediately to the reset values; no partial state survives.
- Back-to-back COMs re-seed the LFSR every cycle and keep st in POSTCOM.
- A SKP inside TS holds the LFSR and still decrements cnt.
- DecodeValid gaps of any length freeze everything, including cnt and the LFSR.
- ScrambleDisable affects only NextScramble. Toggling it never alters LFSR alignment.

## Structure
- Shared package (include header, pcie_rx_defs): symbol constants COM/SKP/PAD, SEED, TSLEN and the state encodings NORM/POSTCOM/TS.
- One sub-module, rx_lfsr8: the 16-bit register with seed, hold and 8-step advance, plus the 8-bit mask output.
- rx_scramble_ctrl itself holds the state machine, counter and qualifier logic.

## Test plan
- Reset release, then COM followed by 3 D bytes 8'h00 -> NextScramble=1 and NextScXor=FF, 17, C0 on the 3 bytes.
- COM, SKP, SKP, SKP, then D 8'h00 -> LFSR held through the SKPs; the data byte mask = 8'hFF; InTs=0 throughout.
- COM, PAD, 14 D bytes, then a D byte -> InTs=1 and NextScramble=0 for 15 symbols. The 16th data byte mask equals the 16th sequence value (8'h8D from SEED, i.e. LFSR advanced 15 times).
- COM, D, 4 D, COM -> TsAbort high for one cycle after the second COM; st=POSTCOM; LFSR re-seeded to FFFF.
- Data stream with DecodeValid low for 5 cycles mid-stream -> masks resume with the next sequence value, no skipped values.
- Data stream with ScrambleDisable=1 and notReset pulsed low mid-TS -> NextScramble=0 throughout. After reset, NextScXor=FF, InTs=0 and TsAbort=0.
